// File: rtl/micro_pkg.sv
// Definitions shared by the fetch sequencer and the instruction decoder:
// FSM state encoding, default address width and jump opcodes.
package micro_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2
    } ps_state_t;

    localparam int ADDR_W = 8;

    localparam logic [3:0] JMP_OP  = 4'b1110;
    localparam logic [3:0] CJMP_OP = 4'b1111;

endpackage

// File: rtl/program_sequencer_sat_counter.sv
// Enable-driven saturating up-counter with asynchronous active-low clear
// and a synchronous soft clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         srst,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count register: clears, then increments on enable until all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (srst) begin
            count_r <= {W{1'b0}};
        end else if (en && (count_r != {W{1'b1}})) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/program_sequencer.sv
// Fetch sequencer: owns the program counter, selects the next program-memory
// address from decoder jump requests, and absorbs memory wait states.
module program_sequencer
    import micro_pkg::*;
#(
    parameter int ADDR_W_P = ADDR_W,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                jump,
    input  logic                conditional_jump,
    input  logic [3:0]          jump_address,
    input  logic                dont_jmp,
    input  logic                hold,
    input  logic                pm_ready,
    output logic [ADDR_W_P-1:0] pm_addr,
    output logic [ADDR_W_P-1:0] pc,
    output logic                instr_valid,
    output logic [CNT_W-1:0]    fetch_count,
    output logic [7:0]          from_PS
);

    ps_state_t             state_r;
    ps_state_t             next_state_s;
    logic [ADDR_W_P-1:0]   pc_r;
    logic [ADDR_W_P-1:0]   pend_addr_r;
    logic [ADDR_W_P-1:0]   pm_addr_s;
    logic [ADDR_W_P-1:0]   target_s;
    logic [ADDR_W_P-1:0]   pc_inc_s;
    logic                  pc_load_s;
    logic                  pend_load_s;
    logic                  instr_valid_s;

    assign pc_inc_s = pc_r + {{(ADDR_W_P-1){1'b0}}, 1'b1};
    // Jumps only replace the low nibble, so targets never leave the page.
    assign target_s = {pc_r[ADDR_W_P-1:4], jump_address};

    // Next-address selection and FSM transitions.
    always_comb begin
        next_state_s  = state_r;
        pm_addr_s     = {ADDR_W_P{1'b0}};
        pc_load_s     = 1'b0;
        pend_load_s   = 1'b0;
        instr_valid_s = 1'b0;
        case (state_r)
            S_BOOT: begin
                next_state_s = S_RUN;
            end
            S_RUN: begin
                if (hold) begin
                    pm_addr_s = pc_r;
                end else if (jump) begin
                    pm_addr_s = target_s;
                end else if (conditional_jump && !dont_jmp) begin
                    pm_addr_s = target_s;
                end else begin
                    pm_addr_s = pc_inc_s;
                end
                if (hold) begin
                    next_state_s = S_RUN;
                end else if (pm_ready) begin
                    pc_load_s     = 1'b1;
                    instr_valid_s = 1'b1;
                end else begin
                    next_state_s = S_WAIT;
                    pend_load_s  = 1'b1;
                end
            end
            S_WAIT: begin
                pm_addr_s = pend_addr_r;
                if (pm_ready) begin
                    pc_load_s    = 1'b1;
                    next_state_s = S_RUN;
                end else begin
                    next_state_s = S_WAIT;
                end
            end
            default: begin
                next_state_s = S_BOOT;
            end
        endcase
    end

    // State, program counter and pending-address registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= S_BOOT;
            pc_r        <= {ADDR_W_P{1'b0}};
            pend_addr_r <= {ADDR_W_P{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (pc_load_s) begin
                pc_r <= pm_addr_s;
            end
            if (pend_load_s) begin
                pend_addr_r <= pm_addr_s;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_fetch_cnt (
        .clk   (clk),
        .rst_n (reset_n),
        .srst  (1'b0),
        .en    (pc_load_s),
        .count (fetch_count)
    );

    assign pm_addr     = pm_addr_s;
    assign pc          = pc_r;
    assign instr_valid = instr_valid_s;
    assign from_PS     = 8'h00;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer.
module tb_program_sequencer;

    logic        clk;
    logic        reset_n;
    logic        jump;
    logic        conditional_jump;
    logic [3:0]  jump_address;
    logic        dont_jmp;
    logic        hold;
    logic        pm_ready;
    logic [7:0]  pm_addr;
    logic [7:0]  pc;
    logic        instr_valid;
    logic [15:0] fetch_count;
    logic [7:0]  from_PS;

    int vectors;
    int errors;
    logic [15:0] cnt_snap;

    program_sequencer #(.ADDR_W_P(8), .CNT_W(16)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .jump             (jump),
        .conditional_jump (conditional_jump),
        .jump_address     (jump_address),
        .dont_jmp         (dont_jmp),
        .hold             (hold),
        .pm_ready         (pm_ready),
        .pm_addr          (pm_addr),
        .pc               (pc),
        .instr_valid      (instr_valid),
        .fetch_count      (fetch_count),
        .from_PS          (from_PS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic advance_to(input logic [7:0] target);
        int n;
        n = 0;
        while (pc !== target && n < 600) begin
            tick();
            n++;
        end
        chk("advance_reached", {8'h00, pc}, {8'h00, target});
    endtask

    initial begin
        int n;
        vectors = 0;
        errors  = 0;
        reset_n = 1'b0;
        jump = 1'b0; conditional_jump = 1'b0; jump_address = 4'h0;
        dont_jmp = 1'b0; hold = 1'b0; pm_ready = 1'b1;
        #1;
        chk("rst_pm_addr", {8'h00, pm_addr}, 16'h0000);
        chk("rst_pc", {8'h00, pc}, 16'h0000);
        chk("rst_count", fetch_count, 16'h0000);
        chk("rst_valid", {15'h0, instr_valid}, 16'h0000);
        chk("from_ps", {8'h00, from_PS}, 16'h0000);

        // Release reset between edges; boot cycle presents address 0.
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("boot_pm_addr", {8'h00, pm_addr}, 16'h0000);
        chk("boot_valid", {15'h0, instr_valid}, 16'h0000);
        tick();
        chk("run1_pc", {8'h00, pc}, 16'h0000);
        chk("run1_pm_addr", {8'h00, pm_addr}, 16'h0001);
        chk("run1_valid", {15'h0, instr_valid}, 16'h0001);
        repeat (10) tick();
        chk("run10_pc", {8'h00, pc}, 16'h000A);
        chk("run10_count", fetch_count, 16'h000A);

        // Hold freezes pc and count and re-issues pc.
        advance_to(8'h10);
        cnt_snap = fetch_count;
        hold = 1'b1;
        #1;
        chk("hold_pm_addr", {8'h00, pm_addr}, 16'h0010);
        chk("hold_valid", {15'h0, instr_valid}, 16'h0000);
        tick();
        chk("hold1_pc", {8'h00, pc}, 16'h0010);
        pm_ready = 1'b0;
        tick();
        chk("hold2_pc", {8'h00, pc}, 16'h0010);
        chk("hold2_count", fetch_count, cnt_snap);
        chk("hold_notready_pm_addr", {8'h00, pm_addr}, 16'h0010);
        hold = 1'b0;
        pm_ready = 1'b1;

        // Wait states capture the jump decision from the first low cycle.
        advance_to(8'h20);
        cnt_snap = fetch_count;
        pm_ready = 1'b0; jump = 1'b1; jump_address = 4'h4;
        #1;
        chk("wait0_pm_addr", {8'h00, pm_addr}, 16'h0024);
        tick();
        jump = 1'b0; jump_address = 4'h0; hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("wait_pm_addr", {8'h00, pm_addr}, 16'h0024);
            chk("wait_valid", {15'h0, instr_valid}, 16'h0000);
            chk("wait_pc", {8'h00, pc}, 16'h0020);
            tick();
        end
        pm_ready = 1'b1; hold = 1'b0;
        #1;
        chk("wait_ready_pm_addr", {8'h00, pm_addr}, 16'h0024);
        tick();
        chk("wait_done_pc", {8'h00, pc}, 16'h0024);
        chk("wait_done_count", fetch_count, cnt_snap + 16'h0001);
        chk("wait_done_pm_addr", {8'h00, pm_addr}, 16'h0025);

        // Unconditional jump.
        advance_to(8'h37);
        jump = 1'b1; jump_address = 4'hA;
        #1;
        chk("jmp_pm_addr", {8'h00, pm_addr}, 16'h003A);
        tick();
        jump = 1'b0;
        #1;
        chk("jmp_pc", {8'h00, pc}, 16'h003A);
        chk("jmp_next_pm_addr", {8'h00, pm_addr}, 16'h003B);

        // Conditional jump taken, then suppressed.
        advance_to(8'h52);
        conditional_jump = 1'b1; jump_address = 4'h1; dont_jmp = 1'b0;
        tick();
        chk("cjmp_taken_pc", {8'h00, pc}, 16'h0051);
        conditional_jump = 1'b0;
        tick();
        conditional_jump = 1'b1; dont_jmp = 1'b1;
        tick();
        chk("cjmp_skip_pc", {8'h00, pc}, 16'h0053);
        jump = 1'b1; jump_address = 4'h5;
        #1;
        chk("both_jmp_pm_addr", {8'h00, pm_addr}, 16'h0055);
        tick();
        jump = 1'b0; conditional_jump = 1'b0; dont_jmp = 1'b0; jump_address = 4'h0;

        // Address wrap.
        advance_to(8'hFF);
        #1;
        chk("wrap_pm_addr", {8'h00, pm_addr}, 16'h0000);
        tick();
        chk("wrap_pc", {8'h00, pc}, 16'h0000);

        // Asynchronous reset in the middle of a wait.
        pm_ready = 1'b0;
        tick();
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_pc", {8'h00, pc}, 16'h0000);
        chk("midrst_count", fetch_count, 16'h0000);
        chk("midrst_pm_addr", {8'h00, pm_addr}, 16'h0000);
        chk("midrst_valid", {15'h0, instr_valid}, 16'h0000);
        pm_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("reboot_pm_addr", {8'h00, pm_addr}, 16'h0000);
        chk("reboot_valid", {15'h0, instr_valid}, 16'h0000);
        tick();
        chk("rerun_pc", {8'h00, pc}, 16'h0000);
        chk("rerun_pm_addr", {8'h00, pm_addr}, 16'h0001);

        // Saturation of the fetch counter.
        n = 0;
        while (fetch_count !== 16'hFFFE && n < 70000) begin
            tick();
            n++;
        end
        chk("sat_reach", fetch_count, 16'hFFFE);
        repeat (5) tick();
        chk("sat_count", fetch_count, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Fetch-side counterpart of the instruction decoder.
- Owns the program counter and drives the program-memory address, so the synchronous ROM returns the `next_instr` byte that the decoder latches into `ir`.
- Consumes the decoder's `jump`, `conditional_jump` and `jump_address` outputs, plus the ALU zero flag.
- Handles wait states from program memory and stalls from downstream, and keeps a retired-fetch counter for debug.

Parameters:
- ADDR_W, 8, program-memory address width; `pc` wraps modulo 2^ADDR_W.
- CNT_W, 16, width of the fetch counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- jump  in  1  unconditional jump request from the decoder.
- conditional_jump  in  1  conditional jump request from the decoder.
- jump_address  in  4  low nibble of the jump target.
- dont_jmp  in  1  ALU zero-flag qualifier; 1 suppresses a conditional jump.
- hold  in  1  downstream stall; re-issue the current address.
- pm_ready  in  1  program memory has valid data for the last address.
- pm_addr  out  ADDR_W  combinational address into program memory.
- pc  out  ADDR_W  registered address of the instruction being fetched.
- instr_valid  out  1  `next_instr` this cycle is a real fetch.
- fetch_count  out  CNT_W  saturating count of accepted fetches.
- from_PS  out  8  debug bus; constant 8'h00.

Behaviour:
- Reset (async, reset_n=0), in effect immediately without waiting for a clock edge:
  - state=S_BOOT, pc=0, fetch_count=0.
  - pm_addr=0, instr_valid=0.
  - Reset asserted mid-operation aborts any wait or stall.
- States: S_BOOT, S_RUN, S_WAIT.
- S_BOOT:
  - Exactly one cycle after reset release.
  - pm_addr=0, instr_valid=0, pc holds 0.
  - Next state is always S_RUN.
- Next-address priority in S_RUN, evaluated combinationally:
  1. hold=1 -> pm_addr=pc.
  2. jump=1 -> pm_addr={pc[ADDR_W-1:4], jump_address}.
  3. conditional_jump=1 and dont_jmp=0 -> same target as jump.
  4. conditional_jump=1 and dont_jmp=1 -> pm_addr=pc+1.
  5. Otherwise -> pm_addr=pc+1, wrapping 8'hFF -> 8'h00.
- Register update in S_RUN:
  - If pm_ready=1 and hold=0: pc<=pm_addr, fetch_count<=fetch_count+1 (saturating at all-ones), instr_valid=1.
  - If pm_ready=0: pc unchanged, go to S_WAIT, instr_valid=0; the jump decision already on pm_addr this cycle is captured into the internal pend_addr register.
- S_WAIT:
  - pm_addr=pend_addr, held stable; instr_valid=0.
  - jump, conditional_jump and hold are ignored.
  - When pm_ready=1: pc<=pend_addr, count increments, return to S_RUN.
- hold=1 and pm_ready=0 together: hold wins; stay in S_RUN, pc unchanged, no count.
- jump and conditional_jump both high: treat as jump (unconditional wins).
- Jump target stays within the current 16-byte page; no page-crossing jumps exist.
- No flush or delay-slot logic: the decoder sees the target instruction one cycle after pm_addr changes.
- from_PS is tied to 8'h00.
- pc and fetch_count are registered outputs; pm_addr and instr_valid are combinational from state and registered values.

Decomposition:
- Shared package (micro_pkg) holds:
  - state encoding: S_BOOT=2'd0, S_RUN=2'd1, S_WAIT=2'd2;
  - ADDR_W default;
  - opcode constants JMP_OP=4'b1110 and CJMP_OP=4'b1111, shared with the decoder.
- One natural sub-module: sat_counter (CNT_W-bit enable-driven saturating counter, async active-low clear), used for fetch_count.
- Next-address mux and FSM stay in program_sequencer.

Test Plan:
- Reset release with pm_ready=1, no jumps:
  - cycle 0: pm_addr=0, instr_valid=0;
  - then pm_addr=0,1,2,...; after 10 run cycles pc=10, fetch_count=10.
- pc=8'h37, jump=1, jump_address=4'hA -> pm_addr=8'h3A; next cycle pc=8'h3A, pm_addr=8'h3B.
- conditional_jump=1 at pc=8'h52, jump_address=4'h1:
  - dont_jmp=0 -> pc becomes 8'h51;
  - dont_jmp=1 -> pc becomes 8'h53.
- At pc=8'h20, pm_ready low 3 cycles with jump_address=4'h4 presented in the first low cycle:
  - pm_addr stays 8'h24 throughout, instr_valid=0;
  - on pm_ready=1, pc=8'h24, fetch_count +1 only once.
- At pc=8'hFF with no jump -> pm_addr=8'h00, no X.
- hold=1 for 2 cycles at pc=8'h10 -> pm_addr=8'h10, pc and count frozen.
- reset_n pulsed low mid-S_WAIT -> outputs reset to 0 immediately, then S_BOOT -> S_RUN.
- fetch_count preloaded to 16'hFFFE -> stays 16'hFFFF after 5 fetches.
